// File: rtl/instr_mem_loadable.sv
// Instruction memory with a valid/ready program loader (IDLE/LOAD/DONE FSM)
// and a registered, single-cycle fetch port that is served only while idle.
module instr_mem_loadable #(
  parameter int unsigned       DATA_W   = 12,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DEPTH    = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  output logic              addr_err
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    w_wr_ptr_nxt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                r_load_ready;
  logic                r_load_done;
  logic [PTR_W-1:0]    r_prog_len;
  logic [DATA_W-1:0]   r_instruction;
  logic                r_instr_valid;
  logic                r_addr_err;

  logic                w_beat;
  logic                w_last_addr;
  logic                w_fetch;
  logic                w_addr_ok;

  // r_load_ready is high exactly while the FSM sits in LOAD
  assign w_beat      = load_valid & r_load_ready;
  assign w_last_addr = (r_wr_ptr == PTR_W'(DEPTH - 1));
  assign w_fetch     = fetch_en & (r_state == S_IDLE);
  assign w_addr_ok   = ({1'b0, fetch_addr} < PTR_W'(DEPTH));

  // Next-state and write-pointer logic
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt  = S_LOAD;
          w_wr_ptr_nxt = '0;
        end
      end
      S_LOAD: begin
        if (w_beat) begin
          w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
          if (load_last || w_last_addr) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state and loader outputs, registered from the next state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_prog_len   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_load_ready <= (w_state_nxt == S_LOAD);
      r_load_done  <= (w_state_nxt == S_DONE);
      if ((r_state == S_LOAD) && (w_state_nxt == S_DONE)) begin
        r_prog_len <= w_wr_ptr_nxt;
      end
    end
  end

  // Storage array; the pointer never reaches DEPTH while a beat is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= NOP_WORD;
      end
    end else if (w_beat) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= load_data;
    end
  end

  // Fetch port: one-cycle latency, out-of-range addresses return NOP_WORD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instruction <= NOP_WORD;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else if (w_fetch) begin
      r_instr_valid <= 1'b1;
      r_addr_err    <= ~w_addr_ok;
      r_instruction <= w_addr_ok ? r_mem[fetch_addr] : NOP_WORD;
    end else begin
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end
  end

  assign load_ready  = r_load_ready;
  assign load_done   = r_load_done;
  assign prog_len    = r_prog_len;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign addr_err    = r_addr_err;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: loads, fetch tables, stall during load,
// full-depth load, out-of-range fetch on a 12-deep copy and reset mid-load.
module tb_instr_mem_loadable;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned ADDR_W = 4;
  localparam logic [DATA_W-1:0] NOP12 = 12'h0F0;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              load_start, load_valid, load_last, fetch_en;
  logic [DATA_W-1:0] load_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic              load_ready, load_done, instr_valid, addr_err;
  logic [ADDR_W:0]   prog_len;
  logic [DATA_W-1:0] instruction;

  logic              b_fetch_en;
  logic [ADDR_W-1:0] b_fetch_addr;
  logic              b_load_ready, b_load_done, b_instr_valid, b_addr_err;
  logic [ADDR_W:0]   b_prog_len;
  logic [DATA_W-1:0] b_instruction;

  always #5 clk = ~clk;

  instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
    .prog_len(prog_len), .fetch_en(fetch_en), .fetch_addr(fetch_addr),
    .instruction(instruction), .instr_valid(instr_valid), .addr_err(addr_err)
  );

  instr_mem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(12), .NOP_WORD(NOP12)) u_dut12 (
    .clk(clk), .reset_n(reset_n),
    .load_start(1'b0), .load_valid(1'b0), .load_data(12'h000),
    .load_last(1'b0), .load_ready(b_load_ready), .load_done(b_load_done),
    .prog_len(b_prog_len), .fetch_en(b_fetch_en), .fetch_addr(b_fetch_addr),
    .instruction(b_instruction), .instr_valid(b_instr_valid), .addr_err(b_addr_err)
  );

  typedef struct {
    logic [DATA_W-1:0] instr;
    logic              valid;
    logic              err;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp_instr;
    logic              exp_err;
  } vec_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model_mem [16];
  int                n_pass = 0;
  int                n_total = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Push the expectation, drive one fetch, then pop and compare the output
  task automatic fetch(input bit sel12, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] ei, input logic ee, input string nm);
    exp_t e;
    exp_q.push_back('{instr: ei, valid: 1'b1, err: ee});
    if (sel12) begin b_fetch_en = 1'b1; b_fetch_addr = a; end
    else begin fetch_en = 1'b1; fetch_addr = a; end
    tick();
    b_fetch_en = 1'b0;
    fetch_en   = 1'b0;
    if (exp_q.size() == 0) begin
      chk({nm, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_instr"}, sel12 ? b_instruction : instruction, e.instr);
      chk({nm, "_valid"}, sel12 ? b_instr_valid : instr_valid, e.valid);
      chk({nm, "_err"},   sel12 ? b_addr_err    : addr_err,    e.err);
    end
  endtask

  initial begin
    vec_t              vt[6];
    logic [DATA_W-1:0] hold;

    vt[0] = '{addr: 4'd0,  exp_instr: 12'hA01, exp_err: 1'b0};
    vt[1] = '{addr: 4'd1,  exp_instr: 12'hB02, exp_err: 1'b0};
    vt[2] = '{addr: 4'd2,  exp_instr: 12'hC03, exp_err: 1'b0};
    vt[3] = '{addr: 4'd3,  exp_instr: 12'h000, exp_err: 1'b0};
    vt[4] = '{addr: 4'd15, exp_instr: 12'h000, exp_err: 1'b0};
    vt[5] = '{addr: 4'd1,  exp_instr: 12'hB02, exp_err: 1'b0};
    for (int i = 0; i < 16; i++) model_mem[i] = '0;

    reset_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; fetch_en = 1'b0; fetch_addr = '0;
    b_fetch_en = 1'b0; b_fetch_addr = '0;
    tick(); tick();
    chk("rst_instr", instruction, 12'h000);
    chk("rst_ready", load_ready, 1'b0);
    chk("rst_done",  load_done,  1'b0);
    chk("rst_plen",  prog_len,   5'd0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_err",   addr_err,   1'b0);
    chk("rst_instr12", b_instruction, NOP12);
    reset_n = 1'b1;
    tick();

    fetch(1'b0, 4'd5, 12'h000, 1'b0, "t1_fetch5");
    tick();
    chk("t1_valid_drop", instr_valid, 1'b0);

    // Three-word program, last on the third beat
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("t2_ready", load_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1;
      load_data  = (i == 0) ? 12'hA01 : (i == 1) ? 12'hB02 : 12'hC03;
      load_last  = (i == 2);
      if (i < 2) chk("t2_no_done", load_done, 1'b0);
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("t2_done",  load_done,  1'b1);
    chk("t2_plen",  prog_len,   5'd3);
    chk("t2_ready_drop", load_ready, 1'b0);
    tick();
    chk("t2_done_pulse", load_done, 1'b0);
    chk("t2_plen_hold",  prog_len,  5'd3);
    for (int i = 0; i < 6; i++) begin
      fetch(1'b0, vt[i].addr, vt[i].exp_instr, vt[i].exp_err, $sformatf("t2_vec%0d", i));
    end

    // Full-depth load with fetch_en held high throughout, plus a stray load_start
    hold = instruction;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    fetch_en = 1'b1; fetch_addr = 4'd15;
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_data  = DATA_W'(12'h100 + i);
      load_start = (i == 5);
      model_mem[i] = DATA_W'(12'h100 + i);
      tick();
      chk($sformatf("t5_stall_valid%0d", i), instr_valid, 1'b0);
      if (i % 4 == 0) chk($sformatf("t5_stall_instr%0d", i), instruction, hold);
    end
    load_start = 1'b0;
    chk("t3_ready_drop", load_ready, 1'b0);
    chk("t3_done",       load_done,  1'b1);
    chk("t3_plen",       prog_len,   5'd16);
    load_data = 12'hFFF;
    tick();
    chk("t5_done_valid", instr_valid, 1'b0);
    chk("t5_done_instr", instruction, hold);
    chk("t3_done_pulse", load_done,   1'b0);
    chk("t3_ready_17",   load_ready,  1'b0);
    exp_q.push_back('{instr: model_mem[15], valid: 1'b1, err: 1'b0});
    tick();
    begin
      exp_t e;
      e = exp_q.pop_front();
      chk("t5_resume_instr", instruction, e.instr);
      chk("t5_resume_valid", instr_valid, e.valid);
    end
    load_valid = 1'b0; fetch_en = 1'b0;
    tick();
    chk("t3_plen_hold", prog_len, 5'd16);
    for (int i = 0; i < 16; i += 3) begin
      fetch(1'b0, ADDR_W'(i), model_mem[i], 1'b0, $sformatf("t3_rd%0d", i));
    end

    // 12-deep instance: boundary and out-of-range fetches
    fetch(1'b1, 4'd13, NOP12, 1'b1, "t4_addr13");
    fetch(1'b1, 4'd12, NOP12, 1'b1, "t4_addr12");
    fetch(1'b1, 4'd11, NOP12, 1'b0, "t4_addr11");
    fetch(1'b1, 4'd15, NOP12, 1'b1, "t4_addr15");

    // Reset after two beats of a new load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = DATA_W'(12'h700 + i);
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("t6_ready", load_ready, 1'b0);
    chk("t6_plen",  prog_len,   5'd0);
    chk("t6_done",  load_done,  1'b0);
    load_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_no_done%0d", i), load_done, 1'b0);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    fetch(1'b0, 4'd0, model_mem[0], 1'b0, "t6_addr0");
    fetch(1'b0, 4'd1, model_mem[1], 1'b0, "t6_addr1");
    chk("t6_plen_after", prog_len, 5'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
